// File: rtl/uart_tx_core_if.sv
// Byte-push and status bundle between the UART register block (master)
// and the transmit core (slave).
interface uart_tx_core_if #(
  parameter int unsigned FIFO_AW = 4
);
  logic [7:0]       tx_data;
  logic             tx_wr;
  logic             rst_tx_fifo;
  logic             tx_fifo_full;
  logic             tx_fifo_empty;
  logic [FIFO_AW:0] tx_fifo_count;
  logic             tx_busy;

  modport master (
    output tx_data, tx_wr, rst_tx_fifo,
    input  tx_fifo_full, tx_fifo_empty, tx_fifo_count, tx_busy
  );

  modport slave (
    input  tx_data, tx_wr, rst_tx_fifo,
    output tx_fifo_full, tx_fifo_empty, tx_fifo_count, tx_busy
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmit core: byte FIFO feeding an 8N1 / 8E1 / 8O1 serialiser.
// txd is driven from a flop so the pin never glitches between states.
module uart_tx_core #(
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_AW    = 4,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_core_if.slave bus,
  output logic          txd
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned BW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_d;
  logic          empty_c, full_c, push_c, pop_c, bit_end_c, can_start_c;
  logic [7:0]    head_c;

  // Flags decode the registered pointers only; tx_wr never reaches them combinationally.
  assign empty_c     = (wr_ptr_q == rd_ptr_q);
  assign full_c      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign push_c      = bus.tx_wr & ~full_c;
  assign head_c      = mem[rd_ptr_q[FIFO_AW-1:0]];
  assign bit_end_c   = (baud_q == BW'(BAUD_DIV - 1));
  // A clear in progress must not launch a frame from stale storage.
  assign can_start_c = ~empty_c & ~bus.rst_tx_fifo;

  assign bus.tx_fifo_empty = empty_c;
  assign bus.tx_fifo_full  = full_c;
  assign bus.tx_fifo_count = wr_ptr_q - rd_ptr_q;
  assign bus.tx_busy       = (state_q != S_IDLE);

  // FIFO storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_c && !bus.rst_tx_fifo) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (bus.rst_tx_fifo) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd     <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd     <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop_c   = 1'b0;
    txd_d   = 1'b1;

    if (state_q != S_IDLE) begin
      baud_d = bit_end_c ? '0 : baud_q + BW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (can_start_c) begin
          pop_c   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end_c) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (can_start_c) begin
            pop_c   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every START entry loads the byte, latches its parity and realigns the baud phase.
    if (pop_c) begin
      shift_d = head_c;
      par_d   = (^head_c) ^ PARITY_ODD;
      baud_d  = '0;
    end

    // Pin value follows the state being entered so it changes with the state flop.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core at BAUD_DIV=4: cycle-exact frame checks, a serial
// decoder draining a byte scoreboard, and parity vectors on two parity builds.
module tb_uart_tx_core;
  localparam int unsigned BD = 4;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic txd_np, txd_pe, txd_po;

  always #5 clk = ~clk;

  uart_tx_core_if #(.FIFO_AW(AW)) np_if ();
  uart_tx_core_if #(.FIFO_AW(AW)) pe_if ();
  uart_tx_core_if #(.FIFO_AW(AW)) po_if ();

  uart_tx_core #(.BAUD_DIV(BD), .FIFO_AW(AW), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_np (
    .clk(clk), .rst_n(rst_n), .bus(np_if.slave), .txd(txd_np));
  uart_tx_core #(.BAUD_DIV(BD), .FIFO_AW(AW), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_pe (
    .clk(clk), .rst_n(rst_n), .bus(pe_if.slave), .txd(txd_pe));
  uart_tx_core #(.BAUD_DIV(BD), .FIFO_AW(AW), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_po (
    .clk(clk), .rst_n(rst_n), .bus(po_if.slave), .txd(txd_po));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  bit mon_en = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } par_vec_t;
  par_vec_t ptab [6];
  logic [7:0] burst [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected pin value at offset off from the first start-bit cycle; p is
  // the parity bit (8N1 passes 1 so that slot reads as stop).
  function automatic logic pframe(input logic [7:0] b, input logic p, input int off);
    logic [2:0] k;
    if (off < 0) return 1'b1;
    if (off < int'(BD)) return 1'b0;
    if (off < 9 * int'(BD)) begin
      k = 3'((off - int'(BD)) / int'(BD));
      return b[k];
    end
    if (off < 10 * int'(BD)) return p;
    return 1'b1;
  endfunction

  // Serial decoder for the 8N1 instance, compared against the scoreboard.
  initial begin : monitor
    logic [7:0] rx;
    rx = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && txd_np == 1'b0) begin
        repeat (2) @(negedge clk);
        chk("mon_start_mid", int'(txd_np), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          rx = {txd_np, rx[7:1]};
        end
        repeat (BD) @(negedge clk);
        chk("mon_stop_bit", int'(txd_np), 1);
        @(negedge clk);
        if (exp_q.size() == 0) chk("mon_unexpected_frame", int'(rx), -1);
        else                   chk("mon_byte", int'(rx), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || np_if.tx_busy || !np_if.tx_fifo_empty ||
            pe_if.tx_busy || po_if.tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(n < budget), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ptab[0] = '{8'h07, 1'b1, 1'b0};
    ptab[1] = '{8'hA5, 1'b0, 1'b1};
    ptab[2] = '{8'h00, 1'b0, 1'b1};
    ptab[3] = '{8'hFF, 1'b0, 1'b1};
    ptab[4] = '{8'h80, 1'b1, 1'b0};
    ptab[5] = '{8'h3C, 1'b0, 1'b1};
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55;
    burst[3] = 8'hAA; burst[4] = 8'h3C;

    rst_n = 1'b0;
    np_if.tx_data = '0; np_if.tx_wr = 1'b0; np_if.rst_tx_fifo = 1'b0;
    pe_if.tx_data = '0; pe_if.tx_wr = 1'b0; pe_if.rst_tx_fifo = 1'b0;
    po_if.tx_data = '0; po_if.tx_wr = 1'b0; po_if.rst_tx_fifo = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", int'(txd_np), 1);
    chk("rst_busy", int'(np_if.tx_busy), 0);
    chk("rst_empty", int'(np_if.tx_fifo_empty), 1);
    chk("rst_full", int'(np_if.tx_fifo_full), 0);
    chk("rst_count", int'(np_if.tx_fifo_count), 0);
    chk("rst_txd_par", int'(txd_pe), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Burst of bytes through the scoreboard.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      np_if.tx_wr = (c < 5);
      if (c < 5) begin
        np_if.tx_data = burst[c];
        exp_q.push_back(burst[c]);
      end
    end
    wait_drain("burst_drain", 400);

    // Single 0xA5 frame, cycle exact.
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      np_if.tx_wr = (c == 0);
      np_if.tx_data = 8'hA5;
      if (c == 0) exp_q.push_back(8'hA5);
      @(negedge clk);
      chk("single_txd", int'(txd_np), int'(pframe(8'hA5, 1'b1, c - 2)));
      chk("single_busy", int'(np_if.tx_busy), int'(c >= 2 && c <= 41));
      if (c == 1) chk("single_empty_c1", int'(np_if.tx_fifo_empty), 0);
      if (c >= 3) chk("single_empty", int'(np_if.tx_fifo_empty), 1);
    end
    wait_drain("single_drain", 100);

    // Back-to-back 0x01 then 0x80: second start directly after first stop.
    for (int c = 0; c < 86; c++) begin
      @(posedge clk); #1;
      np_if.tx_wr = (c < 2);
      np_if.tx_data = (c == 0) ? 8'h01 : 8'h80;
      if (c < 2) exp_q.push_back(np_if.tx_data);
      @(negedge clk);
      if (c < 42) chk("b2b_txd_a", int'(txd_np), int'(pframe(8'h01, 1'b1, c - 2)));
      else        chk("b2b_txd_b", int'(txd_np), int'(pframe(8'h80, 1'b1, c - 42)));
      chk("b2b_busy", int'(np_if.tx_busy), int'(c >= 2 && c <= 81));
      if (c == 1)  chk("b2b_count_c1", int'(np_if.tx_fifo_count), 1);
      if (c == 2)  chk("b2b_count_c2", int'(np_if.tx_fifo_count), 1);
      if (c == 41) chk("b2b_count_c41", int'(np_if.tx_fifo_count), 1);
      if (c == 42) chk("b2b_count_c42", int'(np_if.tx_fifo_count), 0);
    end
    wait_drain("b2b_drain", 100);

    // Fill while busy; a push while full is dropped even when a pop coincides.
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      np_if.tx_wr = (c == 0) || (c >= 3 && c <= 18) || (c == 41);
      np_if.tx_data = (c == 41) ? 8'h11 : (c == 0) ? 8'h00 : 8'(c - 2);
      if (c == 0 || (c >= 3 && c <= 18)) exp_q.push_back(np_if.tx_data);
      @(negedge clk);
      if (c == 19 || c == 30) begin
        chk("ovf_full", int'(np_if.tx_fifo_full), 1);
        chk("ovf_count", int'(np_if.tx_fifo_count), 16);
      end
      if (c == 42) begin
        chk("ovf_full_after_pop", int'(np_if.tx_fifo_full), 0);
        chk("ovf_count_after_pop", int'(np_if.tx_fifo_count), 15);
        chk("ovf_gapless_start", int'(txd_np), 0);
      end
    end
    wait_drain("ovf_drain", 900);

    // FIFO clear during byte 1 data bits: byte 1 finishes, nothing follows.
    for (int c = 0; c < 130; c++) begin
      @(posedge clk); #1;
      np_if.rst_tx_fifo = (c == 10);
      np_if.tx_wr = (c < 3) || (c == 10);
      np_if.tx_data = (c == 10) ? 8'h44 : 8'(8'h11 * (c + 1));
      if (c < 3) exp_q.push_back(np_if.tx_data);
      if (c == 10) while (exp_q.size() > 1) void'(exp_q.pop_back());
      @(negedge clk);
      if (c == 9) chk("clr_count_before", int'(np_if.tx_fifo_count), 2);
      if (c == 11) begin
        chk("clr_empty", int'(np_if.tx_fifo_empty), 1);
        chk("clr_count", int'(np_if.tx_fifo_count), 0);
      end
      if (c == 41) chk("clr_busy_last_stop", int'(np_if.tx_busy), 1);
      if (c >= 42) begin
        chk("clr_idle_busy", int'(np_if.tx_busy), 0);
        chk("clr_idle_txd", int'(txd_np), 1);
      end
    end
    wait_drain("clr_drain", 50);

    // Asynchronous reset in the middle of DATA, then a fresh byte.
    mon_en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      np_if.tx_wr = (c == 0);
      np_if.tx_data = 8'h5A;
      @(negedge clk);
    end
    chk("arst_pre_txd", int'(txd_np), int'(pframe(8'h5A, 1'b1, 13)));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_txd", int'(txd_np), 1);
    chk("arst_busy", int'(np_if.tx_busy), 0);
    chk("arst_empty", int'(np_if.tx_fifo_empty), 1);
    chk("arst_count", int'(np_if.tx_fifo_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    np_if.tx_wr = 1'b1;
    np_if.tx_data = 8'h3C;
    exp_q.push_back(8'h3C);
    @(posedge clk); #1;
    np_if.tx_wr = 1'b0;
    wait_drain("arst_drain", 100);

    // Parity vectors: even and odd builds side by side, 44-cycle frames.
    for (int v = 0; v < 6; v++) begin
      for (int c = 0; c < 48; c++) begin
        @(posedge clk); #1;
        pe_if.tx_wr = (c == 0);
        po_if.tx_wr = (c == 0);
        pe_if.tx_data = ptab[v].data;
        po_if.tx_data = ptab[v].data;
        @(negedge clk);
        chk("par_even_txd", int'(txd_pe), int'(pframe(ptab[v].data, ptab[v].par_even, c - 2)));
        chk("par_odd_txd", int'(txd_po), int'(pframe(ptab[v].data, ptab[v].par_odd, c - 2)));
        chk("par_busy", int'(pe_if.tx_busy), int'(c >= 2 && c <= 45));
      end
    end
    wait_drain("final_drain", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
